idct_mul_sequencer: RTL and testbench

- Drives one conf_int_mul__noFF__arch_agnos__w_wrapper multiplier instance on behalf of the IDCT datapath.
- Accepts a stream of signed operand pairs and issues them to the wrapper with the correct state code, count0, racc, rapx and rstP.
- Tracks the wrapper's 2-cycle latency, accumulates each group of TAPS products into a dot product, and emits one result per group over a valid/ready handshake.
- It is the issuing/consuming end of the multiplier wrapper's control interface.

---
 rtl/idct_mul_sequencer.sv | 242 ++++++++++++++++++++++++
 tb/tb_idct_mul_sequencer.sv | 363 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/idct_mul_sequencer.sv
// Operand issue / product accumulate sequencer for one shared IDCT multiplier wrapper.
// Optional macro SEQ_SAT_OUT_EN: saturate group results to signed OUT_W instead of truncating.
module idct_mul_sequencer #(
    parameter int DATA_PATH_BITWIDTH = 24,
    parameter int TAPS               = 8,
    parameter int ACC_W              = 40,
    parameter int OUT_W              = 32
) (
    input  logic                          clk,
    input  logic                          rstN,
    input  logic                          start,
    input  logic [7:0]                    num_groups,
    input  logic                          mode_row,
    input  logic                          approx_en,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [DATA_PATH_BITWIDTH-1:0] in_a,
    input  logic [DATA_PATH_BITWIDTH-1:0] in_b,
    output logic [DATA_PATH_BITWIDTH-1:0] A_to_mul,
    output logic [DATA_PATH_BITWIDTH-1:0] B_to_mul,
    output logic [2:0]                    state,
    output logic [8:0]                    count0,
    output logic                          rstP,
    output logic                          racc,
    output logic                          rapx,
    input  logic [31:0]                   P,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [OUT_W-1:0]              out_data,
    output logic                          busy,
    output logic                          done
);

    localparam int TAP_W = 5;
    localparam logic [TAP_W-1:0] TAPS_C  = TAP_W'(TAPS);
    localparam logic [TAP_W-1:0] TAPS_M1 = TAP_W'(TAPS - 1);

    typedef enum logic [1:0] {S_IDLE, S_CLR, S_RUN, S_DRAIN} fsm_t;

    fsm_t                          fsm_q, fsm_d;
    logic                          mode_row_q, mode_row_d;
    logic [7:0]                    ngrp_q, ngrp_d;
    logic [7:0]                    grp_q, grp_d;
    logic [TAP_W-1:0]              tap_q, tap_d;
    logic [TAP_W-1:0]              prod_q, prod_d;
    logic signed [ACC_W-1:0]       acc_q, acc_d;
    logic                          v1_q, v1_d;
    logic                          v2_q, v2_d;
    logic [DATA_PATH_BITWIDTH-1:0] a_q, a_d;
    logic [DATA_PATH_BITWIDTH-1:0] b_q, b_d;
    logic [2:0]                    st_q, st_d;
    logic [8:0]                    cnt_q, cnt_d;
    logic                          rstp_q, rstp_d;
    logic                          racc_q, racc_d;
    logic                          rapx_q, rapx_d;
    logic                          ov_q, ov_d;
    logic [OUT_W-1:0]              od_q, od_d;
    logic                          busy_q, busy_d;
    logic                          done_q, done_d;
    logic                          inr_q, inr_d;

    logic                          accept;
    logic signed [ACC_W-1:0]       p_ext;
    logic signed [ACC_W-1:0]       sum;

    function automatic logic [OUT_W-1:0] fmt_out(input logic signed [ACC_W-1:0] v);
`ifdef SEQ_SAT_OUT_EN
        logic signed [ACC_W-1:0] hi;
        logic signed [ACC_W-1:0] lo;
        hi = {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
        lo = {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};
        if (v > hi)
            return {1'b0, {(OUT_W-1){1'b1}}};
        else if (v < lo)
            return {1'b1, {(OUT_W-1){1'b0}}};
        else
            return v[OUT_W-1:0];
`else
        return v[OUT_W-1:0];
`endif
    endfunction

    assign accept = in_valid & inr_q;
    assign p_ext  = {{(ACC_W-32){P[31]}}, P};
    assign sum    = acc_q + p_ext;

    always_comb begin
        fsm_d      = fsm_q;
        mode_row_d = mode_row_q;
        ngrp_d     = ngrp_q;
        grp_d      = grp_q;
        tap_d      = tap_q;
        prod_d     = prod_q;
        acc_d      = acc_q;
        a_d        = a_q;
        b_d        = b_q;
        st_d       = 3'b000;
        cnt_d      = cnt_q;
        rstp_d     = rstp_q;
        racc_d     = racc_q;
        rapx_d     = rapx_q;
        ov_d       = ov_q;
        od_d       = od_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        // Token pipe mirrors the wrapper: issue -> a/b regs -> c reg (P valid).
        v1_d       = (st_q != 3'b000);
        v2_d       = v1_q;

        case (fsm_q)
            S_IDLE: begin
                rstp_d = 1'b1;
                racc_d = 1'b0;
                rapx_d = 1'b0;
                if (start) begin
                    mode_row_d = mode_row;
                    rapx_d     = approx_en;
                    ngrp_d     = (num_groups == 8'd0) ? 8'd1 : num_groups;
                    grp_d      = 8'd0;
                    tap_d      = '0;
                    prod_d     = '0;
                    acc_d      = '0;
                    cnt_d      = '0;
                    busy_d     = 1'b1;
                    fsm_d      = S_CLR;
                end
            end
            S_CLR: begin
                racc_d = 1'b1;
                rstp_d = 1'b1;
                fsm_d  = S_RUN;
            end
            S_RUN: begin
                racc_d = 1'b0;
                rstp_d = 1'b0;
                if (accept) begin
                    a_d   = in_a;
                    b_d   = in_b;
                    st_d  = mode_row_q ? 3'b010 : 3'b011;
                    cnt_d = cnt_q + 9'd1;
                    tap_d = tap_q + 1'b1;
                    if (tap_q == TAPS_M1) begin
                        grp_d = grp_q + 8'd1;
                        if (grp_q == ngrp_q - 8'd1)
                            fsm_d = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                racc_d = 1'b0;
                rstp_d = 1'b0;
                // Issue has stopped, so a visible result here is the job's last one.
                if (ov_q && out_ready) begin
                    busy_d = 1'b0;
                    done_d = 1'b1;
                    fsm_d  = S_IDLE;
                end
            end
            default: fsm_d = S_IDLE;
        endcase

        if (ov_q && out_ready)
            ov_d = 1'b0;

        if (v2_q) begin
            if (prod_q == TAPS_M1) begin
                od_d   = fmt_out(sum);
                ov_d   = 1'b1;
                acc_d  = '0;
                prod_d = '0;
                tap_d  = '0;
            end else begin
                acc_d  = sum;
                prod_d = prod_q + 1'b1;
            end
        end

        inr_d = (fsm_d == S_RUN) && (tap_d < TAPS_C) && !ov_d;
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            fsm_q      <= S_IDLE;
            mode_row_q <= 1'b0;
            ngrp_q     <= 8'd1;
            grp_q      <= 8'd0;
            tap_q      <= '0;
            prod_q     <= '0;
            acc_q      <= '0;
            v1_q       <= 1'b0;
            v2_q       <= 1'b0;
            a_q        <= '0;
            b_q        <= '0;
            st_q       <= 3'b000;
            cnt_q      <= '0;
            rstp_q     <= 1'b1;
            racc_q     <= 1'b1;
            rapx_q     <= 1'b0;
            ov_q       <= 1'b0;
            od_q       <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            inr_q      <= 1'b0;
        end else begin
            fsm_q      <= fsm_d;
            mode_row_q <= mode_row_d;
            ngrp_q     <= ngrp_d;
            grp_q      <= grp_d;
            tap_q      <= tap_d;
            prod_q     <= prod_d;
            acc_q      <= acc_d;
            v1_q       <= v1_d;
            v2_q       <= v2_d;
            a_q        <= a_d;
            b_q        <= b_d;
            st_q       <= st_d;
            cnt_q      <= cnt_d;
            rstp_q     <= rstp_d;
            racc_q     <= racc_d;
            rapx_q     <= rapx_d;
            ov_q       <= ov_d;
            od_q       <= od_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            inr_q      <= inr_d;
        end
    end

    assign in_ready  = inr_q;
    assign A_to_mul  = a_q;
    assign B_to_mul  = b_q;
    assign state     = st_q;
    assign count0    = cnt_q;
    assign rstP      = rstp_q;
    assign racc      = racc_q;
    assign rapx      = rapx_q;
    assign out_valid = ov_q;
    assign out_data  = od_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_idct_mul_sequencer.sv
// Bench for idct_mul_sequencer: wrapper model feeds P, a queue-based group model predicts results.
module tb_idct_mul_sequencer;
    localparam int DW   = 24;
    localparam int TAPS = 8;

    logic          clk = 1'b0;
    logic          rstN;
    logic          start;
    logic [7:0]    num_groups;
    logic          mode_row;
    logic          approx_en;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_a;
    logic [DW-1:0] in_b;
    logic [DW-1:0] A_to_mul;
    logic [DW-1:0] B_to_mul;
    logic [2:0]    state;
    logic [8:0]    count0;
    logic          rstP;
    logic          racc;
    logic          rapx;
    logic [31:0]   P;
    logic          out_valid;
    logic          out_ready;
    logic [31:0]   out_data;
    logic          busy;
    logic          done;

    always #5 clk = ~clk;

    idct_mul_sequencer #(.DATA_PATH_BITWIDTH(DW), .TAPS(TAPS), .ACC_W(40), .OUT_W(32)) dut (
        .clk(clk), .rstN(rstN), .start(start), .num_groups(num_groups),
        .mode_row(mode_row), .approx_en(approx_en), .in_valid(in_valid),
        .in_ready(in_ready), .in_a(in_a), .in_b(in_b), .A_to_mul(A_to_mul),
        .B_to_mul(B_to_mul), .state(state), .count0(count0), .rstP(rstP),
        .racc(racc), .rapx(rapx), .P(P), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .busy(busy), .done(done)
    );

    // Wrapper product: row pass full product, column pass product >> 8, 32-bit result.
    function automatic logic [31:0] wrap_p(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                           input bit row);
        logic signed [47:0] pr;
        pr = $signed(a) * $signed(b);
        return row ? pr[31:0] : pr[39:8];
    endfunction

    function automatic logic [31:0] fmt(input logic signed [39:0] s);
`ifdef SEQ_SAT_OUT_EN
        if (s > $signed(40'h007FFFFFFF)) return 32'h7FFFFFFF;
        if (s < $signed(40'hFF80000000)) return 32'h80000000;
`endif
        return s[31:0];
    endfunction

    // Wrapper model: state 000 holds the registers, otherwise two-register pipe.
    logic [31:0] w_r1 = '0;
    logic [31:0] w_c  = '0;
    logic        w_v1 = 1'b0;
    always @(posedge clk) begin
        if (state == 3'b010 || state == 3'b011) begin
            w_r1 <= wrap_p(A_to_mul, B_to_mul, state == 3'b010);
            w_v1 <= 1'b1;
        end else begin
            w_v1 <= 1'b0;
        end
        if (w_v1) w_c <= w_r1;
    end
    assign P = w_c;

    int          total = 0;
    int          bad   = 0;
    logic [31:0] exp_q[$];
    logic [47:0] iss_q[$];
    logic [DW-1:0] opa[64];
    logic [DW-1:0] opb[64];
    logic [31:0] last_res;
    int          done_cnt;
    int          job_iss;
    bit          cur_row, cur_apx;
    bit          chk_en;
    bit          rnd_ready;
    bit          arm_hold;
    int          hold_cnt;
    bit          prev_ov, prev_acc;
    logic [31:0] prev_data;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, req, $time);
        end
    endtask

    // Single compare process: issues, handshakes, results and done.
    always @(negedge clk) begin
        if (!rstN) begin
            prev_ov = 1'b0;
            prev_acc = 1'b0;
        end else if (chk_en) begin
            if (start && !busy) begin
                job_iss  = 0;
                done_cnt = 0;
            end
            if (state != 3'b000) begin
                check("issue_code", 64'(state), 64'(cur_row ? 3'b010 : 3'b011));
                check("rstP_run", 64'(rstP), 64'(0));
                job_iss++;
                check("count0_issue", 64'(count0), 64'(job_iss % 512));
                check("issue_expected", 64'(iss_q.size() > 0), 64'(1));
                if (iss_q.size() > 0)
                    check("issue_ops", 64'({A_to_mul, B_to_mul}), 64'(iss_q.pop_front()));
            end
            if (in_valid && in_ready) iss_q.push_back({in_a, in_b});
            if (busy) check("rapx_job", 64'(rapx), 64'(cur_apx));
            if (prev_ov && !prev_acc) begin
                check("out_valid_hold", 64'(out_valid), 64'(1));
                check("out_data_hold", 64'(out_data), 64'(prev_data));
            end
            if (out_valid) begin
                check("stall_in_ready", 64'(in_ready), 64'(0));
                if (out_ready) begin
                    check("result_expected", 64'(exp_q.size() > 0), 64'(1));
                    if (exp_q.size() > 0)
                        check("result", 64'(out_data), 64'(exp_q.pop_front()));
                    last_res = out_data;
                end
            end
            prev_ov   = out_valid;
            prev_acc  = out_ready;
            prev_data = out_data;
            if (done) begin
                done_cnt++;
                check("done_count0", 64'(count0), 64'(job_iss % 512));
                check("done_results_left", 64'(exp_q.size()), 64'(0));
                check("done_issues_left", 64'(iss_q.size()), 64'(0));
            end
        end
    end

    // out_ready driver: always-1, random, or held low around the first result.
    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (arm_hold) begin
                out_ready = 1'b0;
                if (out_valid) begin
                    arm_hold = 1'b0;
                    hold_cnt = 20;
                end
            end else if (hold_cnt > 0) begin
                out_ready = 1'b0;
                hold_cnt--;
            end else begin
                out_ready = rnd_ready ? 1'($urandom % 2) : 1'b1;
            end
        end
    end

    task automatic feed(input int n, input int gapmode);
        for (int i = 0; i < n; i++) begin
            bit got;
            int t;
            in_a = opa[i];
            in_b = opb[i];
            if (gapmode == 2) begin
                while ($urandom % 3 == 0) begin
                    in_valid = 1'b0;
                    @(posedge clk);
                    #1;
                end
            end
            in_valid = 1'b1;
            got = 1'b0;
            t = 0;
            while (!got && t < 2000) begin
                @(negedge clk);
                got = in_ready;
                @(posedge clk);
                #1;
                t++;
            end
            in_valid = 1'b0;
            check("feed_accept", 64'(got), 64'(1));
            if (!got) break;
            if (gapmode == 1) begin
                @(posedge clk);
                #1;
            end
        end
    endtask

    task automatic pulse_start(input int ng, input bit row, input bit apx);
        cur_row = row;
        cur_apx = apx;
        start = 1'b1;
        num_groups = 8'(ng);
        mode_row = row;
        approx_en = apx;
        @(posedge clk);
        #1;
        start = 1'b0;
        // Changing these after start must not affect the job.
        mode_row = ~row;
        approx_en = ~apx;
        num_groups = 8'd7;
    endtask

    task automatic do_job(input int ng, input bit row, input bit apx, input int gapmode,
                          input bit hold);
        int nge;
        int t;
        nge = (ng == 0) ? 1 : ng;
        for (int g = 0; g < nge; g++) begin
            logic signed [39:0] s;
            logic [31:0] p;
            s = '0;
            for (int k = 0; k < TAPS; k++) begin
                p = wrap_p(opa[g*TAPS+k], opb[g*TAPS+k], row);
                s = s + {{8{p[31]}}, p};
            end
            exp_q.push_back(fmt(s));
        end
        arm_hold = hold;
        pulse_start(ng, row, apx);
        feed(nge * TAPS, gapmode);
        t = 0;
        while (done_cnt == 0 && t < 3000) begin
            @(posedge clk);
            #1;
            t++;
        end
        repeat (3) @(posedge clk);
        #1;
        check("done_once", 64'(done_cnt), 64'(1));
        check("busy_after_done", 64'(busy), 64'(0));
        check("count0_after_done", 64'(count0), 64'((nge * TAPS) % 512));
        arm_hold = 1'b0;
        hold_cnt = 0;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_busy"}, 64'(busy), 64'(0));
        check({tag, "_done"}, 64'(done), 64'(0));
        check({tag, "_out_valid"}, 64'(out_valid), 64'(0));
        check({tag, "_in_ready"}, 64'(in_ready), 64'(0));
        check({tag, "_rapx"}, 64'(rapx), 64'(0));
        check({tag, "_state"}, 64'(state), 64'(0));
        check({tag, "_count0"}, 64'(count0), 64'(0));
        check({tag, "_rstP"}, 64'(rstP), 64'(1));
        check({tag, "_racc"}, 64'(racc), 64'(1));
        check({tag, "_ops"}, 64'({A_to_mul, B_to_mul}), 64'(0));
        check({tag, "_out_data"}, 64'(out_data), 64'(0));
    endtask

    task automatic fill_const(input logic [DW-1:0] a, input logic [DW-1:0] b);
        for (int i = 0; i < 64; i++) begin
            opa[i] = a;
            opb[i] = b;
        end
    endtask

    task automatic fill_rand();
        for (int i = 0; i < 64; i++) begin
            opa[i] = DW'($urandom);
            opb[i] = DW'($urandom);
        end
    endtask

    initial begin
        rstN = 1'b0;
        start = 1'b0;
        num_groups = 8'd0;
        mode_row = 1'b0;
        approx_en = 1'b0;
        in_valid = 1'b0;
        in_a = '0;
        in_b = '0;
        chk_en = 1'b0;
        rnd_ready = 1'b0;
        arm_hold = 1'b0;
        hold_cnt = 0;
        done_cnt = 0;
        job_iss = 0;
        last_res = '0;
        repeat (3) @(posedge clk);
        #2;
        check_reset_vals("reset");
        @(posedge clk);
        #1;
        rstN = 1'b1;
        chk_en = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Column pass, each P = 0x200.
        fill_const(24'h000100, 24'h000200);
        do_job(1, 1'b0, 1'b1, 0, 1'b0);
        check("col_literal", 64'(last_res), 64'(32'h00001000));

        // Row pass, each P = 0x20000.
        do_job(1, 1'b1, 1'b0, 0, 1'b0);
        check("row_literal", 64'(last_res), 64'(32'h00100000));

        // Sum of 2^33 overflows OUT_W.
        fill_const(24'h400000, 24'h010000);
        do_job(1, 1'b0, 1'b0, 0, 1'b0);
`ifdef SEQ_SAT_OUT_EN
        check("overflow_literal", 64'(last_res), 64'(32'h7FFFFFFF));
`else
        check("overflow_literal", 64'(last_res), 64'(32'h00000000));
`endif

        // Three groups with the consumer stalled after the first result.
        fill_rand();
        do_job(3, 1'b0, 1'b0, 0, 1'b1);

        // Toggled in_valid gives the same result as the gapless run.
        fill_const(24'h000100, 24'h000200);
        do_job(1, 1'b0, 1'b0, 1, 1'b0);
        check("toggle_literal", 64'(last_res), 64'(32'h00001000));

        // num_groups = 0 behaves as one group.
        fill_rand();
        do_job(0, 1'b1, 1'b1, 0, 1'b0);

        // Reset mid-group, then a clean job.
        fill_const(24'h7FFFFF, 24'h7FFFFF);
        pulse_start(1, 1'b0, 1'b1);
        feed(3, 0);
        #2;
        chk_en = 1'b0;
        rstN = 1'b0;
        #1;
        check_reset_vals("midreset");
        exp_q.delete();
        iss_q.delete();
        @(posedge clk);
        #1;
        rstN = 1'b1;
        chk_en = 1'b1;
        @(posedge clk);
        #1;
        fill_const(24'h000100, 24'h000200);
        do_job(1, 1'b0, 1'b0, 0, 1'b0);
        check("after_reset_literal", 64'(last_res), 64'(32'h00001000));

        // Randomized jobs with random valid gaps and backpressure.
        rnd_ready = 1'b1;
        for (int j = 0; j < 8; j++) begin
            fill_rand();
            do_job(int'($urandom_range(0, 3)), 1'($urandom % 2), 1'($urandom % 2), 2, 1'b0);
        end
        rnd_ready = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
